ysyx_22050243_load_ctrl: RTL and testbench

Load-sequencing controller for the MEM stage of the ysyx_22050243 core. It accepts one load request from the pipeline, issues a single 64-bit aligned read on the data-memory read channel and captures the returned beat. It then shifts the addressed bytes into place, sign- or zero-extends them per funct3, and hands the result to writeback over a valid/ready handshake. It owns all load-path sequencing, misalignment detection and bus-error reporting.

---
 rtl/ysyx_22050243_pkg.sv | 35 +++
 rtl/ysyx_22050243_load_ctrl_if.sv | 45 ++++
 rtl/ysyx_22050243_load_align.sv | 28 ++
 rtl/ysyx_22050243_load_ctrl.sv | 98 +++++++++
 tb/tb_ysyx_22050243_load_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050243_pkg.sv
// Shared constants and helpers for the ysyx_22050243 MEM-stage load path.
// Holds RV64 load funct3 encodings, load-controller states and bus response codes.
package ysyx_22050243_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RESP = 2'd3
    } load_state_e;

    // High when the request can never reach the bus: funct3 111 or a misaligned access.
    function automatic logic load_bad(input logic [2:0] funct3, input logic [2:0] off);
        logic bad;
        case (funct3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = off[0];
            F3_LW, F3_LWU: bad = |off[1:0];
            F3_LD:         bad = |off;
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_22050243_load_ctrl_if.sv
// Pipeline request, data-memory read channel and writeback response of the load controller.
// The master modport is the controller side; the slave modport is its environment.
interface ysyx_22050243_load_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [2:0]            req_funct3_i;
    logic [4:0]            req_rd_i;

    logic                  mem_arvalid_o;
    logic                  mem_arready_i;
    logic [ADDR_WIDTH-1:0] mem_araddr_o;
    logic                  mem_rvalid_i;
    logic                  mem_rready_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic [1:0]            mem_rresp_i;

    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [DATA_WIDTH-1:0] resp_data_o;
    logic [4:0]            resp_rd_o;
    logic                  resp_err_o;

    modport master (
        input  req_valid_i, req_addr_i, req_funct3_i, req_rd_i,
        output req_ready_o,
        output mem_arvalid_o, mem_araddr_o, mem_rready_o,
        input  mem_arready_i, mem_rvalid_i, mem_rdata_i, mem_rresp_i,
        output resp_valid_o, resp_data_o, resp_rd_o, resp_err_o,
        input  resp_ready_i
    );

    modport slave (
        output req_valid_i, req_addr_i, req_funct3_i, req_rd_i,
        input  req_ready_o,
        input  mem_arvalid_o, mem_araddr_o, mem_rready_o,
        output mem_arready_i, mem_rvalid_i, mem_rdata_i, mem_rresp_i,
        input  resp_valid_o, resp_data_o, resp_rd_o, resp_err_o,
        output resp_ready_i
    );

endinterface

// File: rtl/ysyx_22050243_load_align.sv
// Combinational load aligner: shifts the addressed bytes of an 8-byte beat down to bit 0
// and sign- or zero-extends them to 64 bits according to funct3.
module ysyx_22050243_load_align
    import ysyx_22050243_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (funct3)
            F3_LB:   data = {{56{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   data = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   data = shifted;
            F3_LBU:  data = {56'd0, shifted[7:0]};
            F3_LHU:  data = {48'd0, shifted[15:0]};
            F3_LWU:  data = {32'd0, shifted[31:0]};
            default: data = 64'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050243_load_ctrl.sv
// MEM-stage load controller: accepts one load, issues a single aligned 64-bit read,
// aligns/extends the returned beat and hands it to writeback with error reporting.
module ysyx_22050243_load_ctrl
    import ysyx_22050243_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64
) (
    input logic                        clock,
    input logic                        reset,
    ysyx_22050243_load_ctrl_if.master  bus
);

    load_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [63:0]           align_data;

    ysyx_22050243_load_align u_align (
        .rdata  (bus.mem_rdata_i),
        .off    (addr_q[2:0]),
        .funct3 (funct3_q),
        .data   (align_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        data_d   = data_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    addr_d   = bus.req_addr_i;
                    funct3_d = bus.req_funct3_i;
                    rd_d     = bus.req_rd_i;
                    err_d    = 1'b0;
                    // Rejected loads skip the bus and answer straight away with zero data.
                    if (load_bad(bus.req_funct3_i, bus.req_addr_i[2:0])) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = AR;
                    end
                end
            end
            AR: begin
                if (bus.mem_arready_i) state_d = R;
            end
            R: begin
                if (bus.mem_rvalid_i) begin
                    data_d  = align_data;
                    err_d   = (bus.mem_rresp_i != RRESP_OKAY);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is masked by reset so it reads 0 while reset is held.
    assign bus.req_ready_o   = (state_q == IDLE) && !reset;
    assign bus.mem_arvalid_o = (state_q == AR);
    assign bus.mem_araddr_o  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign bus.mem_rready_o  = (state_q == R);
    assign bus.resp_valid_o  = (state_q == RESP);
    assign bus.resp_data_o   = data_q;
    assign bus.resp_rd_o     = rd_q;
    assign bus.resp_err_o    = err_q;

endmodule

// File: tb/tb_ysyx_22050243_load_ctrl.sv
// Directed self-checking bench for ysyx_22050243_load_ctrl with a cycle-stepped slave model.
module tb_ysyx_22050243_load_ctrl;
    import ysyx_22050243_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_22050243_load_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

    ysyx_22050243_load_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] got_data;
    logic        got_err;
    logic [4:0]  got_rd;
    logic        ready_after;
    int          resp_cycle, ar_cycles, addr_errs, hold_errs, ready_errs;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid_i   = 1'b0;
        bus.req_addr_i    = '0;
        bus.req_funct3_i  = '0;
        bus.req_rd_i      = '0;
        bus.mem_arready_i = 1'b0;
        bus.mem_rvalid_i  = 1'b0;
        bus.mem_rdata_i   = '0;
        bus.mem_rresp_i   = '0;
        bus.resp_ready_i  = 1'b0;
    endtask

    // Issues one load at the current cycle and plays memory/writeback with the given delays.
    // noisy keeps req_valid and a junk read beat asserted whenever the DUT should ignore them.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [63:0] rdata, input logic [1:0] rresp,
                            input int ar_dly, input int r_dly, input int resp_dly,
                            input bit noisy);
        int  ar_n = 0;
        int  r_n = 0;
        int  rs_n = 0;
        bit  done = 1'b0;
        logic [31:0] exp_araddr;
        exp_araddr = {addr[31:3], 3'b000};
        resp_cycle = -1; ar_cycles = 0; addr_errs = 0; hold_errs = 0; ready_errs = 0;
        got_data = '0; got_err = 1'b0; got_rd = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c == 0) begin
                if (bus.req_ready_o !== 1'b1) ready_errs++;
                bus.req_valid_i  = 1'b1;
                bus.req_addr_i   = addr;
                bus.req_funct3_i = f3;
                bus.req_rd_i     = rd;
            end else begin
                if (bus.req_ready_o !== 1'b0) ready_errs++;
                bus.req_valid_i  = noisy;
                bus.req_addr_i   = ~addr;
                bus.req_funct3_i = f3 ^ 3'b011;
                bus.req_rd_i     = ~rd;
            end
            if (bus.mem_arvalid_o === 1'b1) begin
                ar_n++;
                ar_cycles++;
                if (bus.mem_araddr_o !== exp_araddr) addr_errs++;
                bus.mem_arready_i = (ar_n > ar_dly);
            end else begin
                bus.mem_arready_i = 1'b0;
            end
            if (bus.mem_rready_o === 1'b1) begin
                r_n++;
                bus.mem_rvalid_i = (r_n > r_dly);
                bus.mem_rdata_i  = (r_n > r_dly) ? rdata : 64'hDEAD_BEEF_DEAD_BEEF;
                bus.mem_rresp_i  = rresp;
            end else begin
                bus.mem_rvalid_i = noisy;
                bus.mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
                bus.mem_rresp_i  = 2'b11;
            end
            if (bus.resp_valid_o === 1'b1) begin
                if (rs_n == 0) begin
                    resp_cycle = c;
                    got_data   = bus.resp_data_o;
                    got_err    = bus.resp_err_o;
                    got_rd     = bus.resp_rd_o;
                end else if (bus.resp_data_o !== got_data || bus.resp_err_o !== got_err ||
                             bus.resp_rd_o !== got_rd) begin
                    hold_errs++;
                end
                rs_n++;
                bus.resp_ready_i = (rs_n > resp_dly);
                done = (rs_n > resp_dly);
            end else begin
                bus.resp_ready_i = 1'b0;
            end
            step();
        end
        ready_after = bus.req_ready_o;
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        total++;
        if ({bus.req_ready_o, bus.mem_arvalid_o, bus.mem_rready_o, bus.resp_valid_o,
             bus.resp_err_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {bus.req_ready_o, bus.mem_arvalid_o,
                     bus.mem_rready_o, bus.resp_valid_o, bus.resp_err_o});
        end
        total++;
        if (bus.resp_data_o !== 64'd0 || bus.resp_rd_o !== 5'd0 || bus.mem_araddr_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: got data=%h rd=%0d araddr=%h want 0", bus.resp_data_o,
                     bus.resp_rd_o, bus.mem_araddr_o);
        end
        reset = 1'b0;
        step();
        total++;
        if (bus.req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", bus.req_ready_o);
        end
    endtask

    task automatic test_lb();
        run_load(32'h8000_0003, F3_LB, 5'd5, 64'h0000_0000_8000_0000, 2'b00, 0, 0, 0, 1'b0);
        total++;
        if (got_data !== 64'hFFFF_FFFF_FFFF_FF80 || got_err !== 1'b0 || got_rd !== 5'd5) begin
            bad++;
            $display("FAIL lb_result: got data=%h err=%b rd=%0d want ffffffffffffff80 0 5",
                     got_data, got_err, got_rd);
        end
        total++;
        if (resp_cycle !== 3 || ar_cycles !== 1) begin
            bad++;
            $display("FAIL lb_latency: got resp_cycle=%0d ar_cycles=%0d want 3 1",
                     resp_cycle, ar_cycles);
        end
        total++;
        if (ready_after !== 1'b1 || ready_errs !== 0) begin
            bad++;
            $display("FAIL lb_ready: got after=%b errs=%0d want 1 0", ready_after, ready_errs);
        end
    endtask

    task automatic test_extend();
        run_load(32'h8000_0006, F3_LHU, 5'd6, 64'hBEEF_0000_0000_0000, 2'b00, 0, 0, 0, 1'b0);
        total++;
        if (got_data !== 64'h0000_0000_0000_BEEF || got_err !== 1'b0 || resp_cycle !== 3) begin
            bad++;
            $display("FAIL lhu: got data=%h err=%b cyc=%0d want 000000000000beef 0 3",
                     got_data, got_err, resp_cycle);
        end
        run_load(32'h8000_0006, F3_LH, 5'd7, 64'hBEEF_0000_0000_0000, 2'b00, 0, 0, 0, 1'b0);
        total++;
        if (got_data !== 64'hFFFF_FFFF_FFFF_BEEF || got_err !== 1'b0) begin
            bad++;
            $display("FAIL lh: got data=%h err=%b want ffffffffffffbeef 0", got_data, got_err);
        end
        run_load(32'h8000_0003, F3_LBU, 5'd8, 64'h0000_0000_8000_0000, 2'b00, 0, 0, 0, 1'b0);
        total++;
        if (got_data !== 64'h0000_0000_0000_0080) begin
            bad++;
            $display("FAIL lbu: got data=%h want 0000000000000080", got_data);
        end
        run_load(32'h8000_0004, F3_LW, 5'd9, 64'h8765_4321_0000_0000, 2'b00, 0, 0, 0, 1'b0);
        total++;
        if (got_data !== 64'hFFFF_FFFF_8765_4321) begin
            bad++;
            $display("FAIL lw_hi: got data=%h want ffffffff87654321", got_data);
        end
    endtask

    task automatic test_misaligned();
        run_load(32'h8000_0002, F3_LW, 5'd3, 64'h1111_1111_1111_1111, 2'b00, 0, 0, 0, 1'b0);
        total++;
        if (got_data !== 64'd0 || got_err !== 1'b1 || got_rd !== 5'd3) begin
            bad++;
            $display("FAIL lw_misaligned: got data=%h err=%b rd=%0d want 0 1 3",
                     got_data, got_err, got_rd);
        end
        total++;
        if (resp_cycle !== 1 || ar_cycles !== 0 || ready_after !== 1'b1) begin
            bad++;
            $display("FAIL lw_misaligned_path: got cyc=%0d ar=%0d rdy=%b want 1 0 1",
                     resp_cycle, ar_cycles, ready_after);
        end
        run_load(32'h8000_0000, 3'b111, 5'd4, 64'h1111_1111_1111_1111, 2'b00, 0, 0, 0, 1'b0);
        total++;
        if (got_data !== 64'd0 || got_err !== 1'b1 || resp_cycle !== 1 || ar_cycles !== 0) begin
            bad++;
            $display("FAIL illegal_f3: got data=%h err=%b cyc=%0d ar=%0d want 0 1 1 0",
                     got_data, got_err, resp_cycle, ar_cycles);
        end
        run_load(32'h8000_0004, F3_LD, 5'd2, 64'h1111_1111_1111_1111, 2'b00, 0, 0, 0, 1'b0);
        total++;
        if (got_err !== 1'b1 || ar_cycles !== 0) begin
            bad++;
            $display("FAIL ld_misaligned: got err=%b ar=%0d want 1 0", got_err, ar_cycles);
        end
    endtask

    task automatic test_back_pressure();
        run_load(32'h8000_0008, F3_LD, 5'd17, 64'h0123_4567_89AB_CDEF, 2'b00, 3, 2, 2, 1'b1);
        total++;
        if (addr_errs !== 0 || ar_cycles !== 4) begin
            bad++;
            $display("FAIL bp_araddr: got addr_errs=%0d ar_cycles=%0d want 0 4",
                     addr_errs, ar_cycles);
        end
        total++;
        if (got_data !== 64'h0123_4567_89AB_CDEF || got_rd !== 5'd17 || got_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_result: got data=%h rd=%0d err=%b want 0123456789abcdef 17 0",
                     got_data, got_rd, got_err);
        end
        total++;
        if (resp_cycle !== 8 || hold_errs !== 0) begin
            bad++;
            $display("FAIL bp_resp: got cyc=%0d hold_errs=%0d want 8 0", resp_cycle, hold_errs);
        end
        total++;
        if (ready_errs !== 0 || ready_after !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready: got errs=%0d after=%b want 0 1", ready_errs, ready_after);
        end
    endtask

    task automatic test_bus_error();
        run_load(32'h8000_0010, F3_LWU, 5'd18, 64'hFFFF_FFFF_1234_5678, 2'b10, 0, 0, 0, 1'b0);
        total++;
        if (got_data !== 64'h0000_0000_1234_5678 || got_err !== 1'b1 || got_rd !== 5'd18) begin
            bad++;
            $display("FAIL bus_error: got data=%h err=%b rd=%0d want 0000000012345678 1 18",
                     got_data, got_err, got_rd);
        end
    endtask

    task automatic test_reset_in_r();
        bus.req_valid_i  = 1'b1;
        bus.req_addr_i   = 32'h8000_0020;
        bus.req_funct3_i = F3_LD;
        bus.req_rd_i     = 5'd9;
        step();
        bus.req_valid_i = 1'b0;
        total++;
        if (bus.mem_arvalid_o !== 1'b1) begin
            bad++;
            $display("FAIL rir_arvalid: got %b want 1", bus.mem_arvalid_o);
        end
        bus.mem_arready_i = 1'b1;
        step();
        bus.mem_arready_i = 1'b0;
        step();
        total++;
        if (bus.mem_rready_o !== 1'b1) begin
            bad++;
            $display("FAIL rir_in_r: got rready=%b want 1", bus.mem_rready_o);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({bus.req_ready_o, bus.mem_arvalid_o, bus.mem_rready_o, bus.resp_valid_o,
             bus.resp_err_o} !== 5'b0 || bus.resp_data_o !== 64'd0 || bus.resp_rd_o !== 5'd0) begin
            bad++;
            $display("FAIL rir_reset_outputs: got ctl=%b data=%h rd=%0d want 0",
                     {bus.req_ready_o, bus.mem_arvalid_o, bus.mem_rready_o, bus.resp_valid_o,
                      bus.resp_err_o}, bus.resp_data_o, bus.resp_rd_o);
        end
        step();
        step();
        reset = 1'b0;
        step();
        total++;
        if (bus.req_ready_o !== 1'b1 || bus.mem_rready_o !== 1'b0) begin
            bad++;
            $display("FAIL rir_release: got ready=%b rready=%b want 1 0",
                     bus.req_ready_o, bus.mem_rready_o);
        end
        run_load(32'h8000_0001, F3_LB, 5'd10, 64'h0000_0000_0000_7F00, 2'b00, 0, 0, 0, 1'b0);
        total++;
        if (got_data !== 64'h0000_0000_0000_007F || got_err !== 1'b0 || resp_cycle !== 3) begin
            bad++;
            $display("FAIL rir_lb: got data=%h err=%b cyc=%0d want 000000000000007f 0 3",
                     got_data, got_err, resp_cycle);
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_extend();
        test_misaligned();
        test_back_pressure();
        test_bus_error();
        test_reset_in_r();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
